y86_elastic_pipe_reg: RTL and testbench
=======================================

// Module: y86_elastic_pipe_reg
// PURPOSE
//  Parametrised elastic pipeline register for the Y86 pipeline (F->D first, reusable at D/E, E/M, M/W).
//  Carries one packed stage payload, keeps bubble/stall control with bubble priority, and adds a
//  valid/ready handshake with an optional 2-entry skid buffer so in_ready_o is registered.
//  Also provides saturating stall/bubble event counters for performance debug.
// PARAMETERS
//  DATA_W      147          payload width ({stat[2:0],icode,ifun,rA,rB,valC[63:0],valP[63:0]} for F->D)
//  BUBBLE_VAL  NOP_PAYLOAD  payload loaded on bubble/reset (stat=0, icode=INOP, ifun=FNONE, rest 0)
//  SKID        1            1 = 2-entry skid buffer (registered ready); 0 = single register
//  CNT_W       32           width of each event counter
// PORTS
//  clk_i        in   1       clock, all state updates on rising edge
//  rst_n_i      in   1       synchronous active-low reset
//  bubble_i     in   1       load BUBBLE_VAL this edge (pipeline control, overrides stall)
//  stall_i      in   1       block enqueue this edge; contents held
//  in_valid_i   in   1       upstream payload valid
//  in_ready_o   out  1       stage accepts payload this cycle
//  in_data_i    in   DATA_W  upstream payload
//  out_valid_o  out  1       out_data_o valid
//  out_ready_i  in   1       downstream consumes out_data_o this cycle
//  out_data_o   out  DATA_W  head payload (registered)
//  occ_o        out  2       occupancy 0..2 (max 1 when SKID=0)
//  stall_cnt_o  out  CNT_W   cycles with stall_i=1 (saturating)
//  bubble_cnt_o out  CNT_W   cycles with bubble_i=1 (saturating)
// BEHAVIOUR
//  - Clocking: single clock; rst_n_i sampled on clk_i rising edge only, active low.
//  - Reset: state EMPTY, out_valid_o=0, out_data_o=BUBBLE_VAL, skid cleared, occ_o=0, counters 0.
//    Reset mid-operation discards main and skid contents; no handshake completes that edge.
//  - Fires: in_fire = in_valid_i & in_ready_o; out_fire = out_valid_o & out_ready_i.
//  - Priority per edge: reset > bubble_i > stall_i > handshake.
//  - States (SKID=1): EMPTY (occ 0), ONE (main full), TWO (main+skid full).
//    EMPTY: in_fire -> ONE, main<=in_data_i.
//    ONE: in_fire&out_fire -> ONE, main<=in; out_fire only -> EMPTY; in_fire only -> TWO, skid<=in.
//    TWO: out_fire -> ONE, main<=skid. No enqueue possible.
//  - in_ready_o (SKID=1) = (state!=TWO) & ~stall_i & ~bubble_i; state term is a register.
//  - in_ready_o (SKID=0) = (~out_valid_o | out_ready_i) & ~stall_i & ~bubble_i (comb. pass-through).
//  - stall_i: blocks enqueue only; dequeue via out_fire still proceeds; payload bits otherwise held.
//  - bubble_i: main<=BUBBLE_VAL, out_valid_o<=1, skid dropped, state->ONE regardless of out_fire;
//    no enqueue that edge. Bubble with stall_i=1: bubble wins (same as legacy D register).
//  - Latency: in_fire at edge N -> visible on out_data_o after edge N when stage was EMPTY or
//    draining; throughput 1 payload/cycle with out_ready_i=1.
//  - Ordering strictly FIFO; no payload duplicated or lost except by bubble/reset.
//  - Counters increment by 1 on each edge with their input high, saturate at all-ones, never wrap;
//    counting is independent of occupancy.
//  - occ_o registered, equals state encoding; out_data_o never X after reset.
// STRUCTURE
//  - Package y86_pipe_pkg: INOP/FNONE/stat encodings, field widths, FD_PAYLOAD_W=147,
//    NOP_PAYLOAD constant, pack/unpack functions, state enum {EMPTY,ONE,TWO}.
//  - Sub-module y86_sat_counter (CNT_W param, inc_i, rst_n_i), instantiated twice.
//  - Skid logic generated under SKID; SKID=0 builds no skid register.
// TESTING
//  1 Reset: hold rst_n_i=0 3 cycles with in_valid_i=1 -> occ_o=0, out_valid_o=0, out_data_o=NOP_PAYLOAD.
//  2 Streaming: 8 payloads 0x1..0x8 back-to-back, out_ready_i=1 -> same order, 1 per cycle, 1-cycle latency.
//  3 Backpressure (SKID=1): out_ready_i=0 with 3 offers -> 2 accepted, occ_o=2, in_ready_o=0;
//    release -> drains A,B in order, third accepted once occ_o<2.
//  4 Bubble vs stall: occ_o=2, bubble_i=1 & stall_i=1 -> next cycle occ_o=1, out_data_o=NOP_PAYLOAD,
//    bubble_cnt_o=1, stall_cnt_o=1.
//  5 Stall: stall_i=1 for 5 cycles, in_valid_i=1, out_ready_i=1 -> no accept, main drains, stall_cnt_o=5.
//  6 Saturation (CNT_W=4): stall_i=1 for 20 cycles -> stall_cnt_o=15 and stays 15; SKID=0 rerun of 2,3.

Source files
------------

// File: rtl/y86_pipe_pkg.sv
// Shared Y86 pipeline encodings, F->D payload layout and elastic-register state type.
package y86_pipe_pkg;

  localparam int unsigned STAT_W  = 3;
  localparam int unsigned ICODE_W = 4;
  localparam int unsigned IFUN_W  = 4;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned WORD_W  = 64;
  localparam int unsigned FD_PAYLOAD_W = STAT_W + ICODE_W + IFUN_W + 2*REG_W + 2*WORD_W;

  localparam logic [STAT_W-1:0]  STAT_BUB = 3'd0;
  localparam logic [STAT_W-1:0]  STAT_AOK = 3'd1;
  localparam logic [STAT_W-1:0]  STAT_HLT = 3'd2;
  localparam logic [STAT_W-1:0]  STAT_ADR = 3'd3;
  localparam logic [STAT_W-1:0]  STAT_INS = 3'd4;
  localparam logic [ICODE_W-1:0] INOP     = 4'h1;
  localparam logic [IFUN_W-1:0]  FNONE    = 4'h0;

  typedef struct packed {
    logic [STAT_W-1:0]  stat;
    logic [ICODE_W-1:0] icode;
    logic [IFUN_W-1:0]  ifun;
    logic [REG_W-1:0]   ra;
    logic [REG_W-1:0]   rb;
    logic [WORD_W-1:0]  valc;
    logic [WORD_W-1:0]  valp;
  } fd_payload_t;

  localparam logic [FD_PAYLOAD_W-1:0] NOP_PAYLOAD =
    {STAT_BUB, INOP, FNONE, {(2*REG_W + 2*WORD_W){1'b0}}};

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  function automatic logic [FD_PAYLOAD_W-1:0] pack_fd(input fd_payload_t p);
    return FD_PAYLOAD_W'(p);
  endfunction

  function automatic fd_payload_t unpack_fd(input logic [FD_PAYLOAD_W-1:0] v);
    return fd_payload_t'(v);
  endfunction

endpackage

// File: rtl/y86_sat_counter.sv
// Event counter that increments on each enabled edge and sticks at all-ones.
module y86_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: rtl/y86_elastic_pipe_reg.sv
// Elastic pipeline register with bubble/stall control, optional 2-entry skid buffer
// and saturating stall/bubble event counters.
module y86_elastic_pipe_reg
  import y86_pipe_pkg::*;
#(
  parameter int unsigned       DATA_W     = FD_PAYLOAD_W,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = DATA_W'(NOP_PAYLOAD),
  parameter bit                SKID       = 1'b1,
  parameter int unsigned       CNT_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              bubble_i,
  input  logic              stall_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occ_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_head;
  logic              in_fire, out_fire;

  assign out_valid_o = (state_q != EMPTY);
  assign occ_o       = 2'(state_q);
  assign out_data_o  = main_q;
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = out_valid_o & out_ready_i;

  // Stall needs no explicit handling here: it only gates in_ready_o.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    if (bubble_i) begin
      state_d = ONE;
      main_d  = BUBBLE_VAL;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = in_data_i;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data_i;
          end else if (out_fire) begin
            state_d = EMPTY;
          end else if (in_fire) begin
            state_d = TWO;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_head;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  if (SKID) begin : g_skid
    logic [DATA_W-1:0] skid_q;
    logic              skid_load;

    // Skid captures the arrival that finds main full and not draining.
    assign skid_load = (state_q == ONE) & in_fire & ~out_fire;

    always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
        skid_q <= '0;
      end else if (skid_load) begin
        skid_q <= in_data_i;
      end
    end

    assign skid_head  = skid_q;
    assign in_ready_o = (state_q != TWO) & ~stall_i & ~bubble_i;
  end else begin : g_noskid
    assign skid_head  = BUBBLE_VAL;
    assign in_ready_o = (~out_valid_o | out_ready_i) & ~stall_i & ~bubble_i;
  end

  y86_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (stall_i),
    .cnt_o   (stall_cnt_o)
  );

  y86_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (bubble_i),
    .cnt_o   (bubble_cnt_o)
  );

endmodule

// File: tb/tb_y86_elastic_pipe_reg.sv
// Drives a skid and a no-skid instance with shared stimulus and compares both
// against queue-based reference models every cycle.
module tb_y86_elastic_pipe_reg;

  localparam int unsigned DW   = 147;
  localparam int unsigned CW   = 4;
  localparam int unsigned CMAX = 15;

  logic          clk = 1'b0;
  logic          rst_n, bubble, stall, in_valid, out_ready;
  logic [DW-1:0] in_data;

  logic          rdy1, ov1, rdy0, ov0;
  logic [DW-1:0] od1, od0;
  logic [1:0]    occ1, occ0;
  logic [CW-1:0] sc1, bc1, sc0, bc0;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] nop;
  logic [DW-1:0] q1[$];
  logic [DW-1:0] q0[$];
  int unsigned   scm = 0, bcm = 0;
  bit            known = 1'b0;

  always #5 clk = ~clk;

  y86_elastic_pipe_reg #(.SKID(1'b1), .CNT_W(CW)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .bubble_i(bubble), .stall_i(stall),
    .in_valid_i(in_valid), .in_ready_o(rdy1), .in_data_i(in_data),
    .out_valid_o(ov1), .out_ready_i(out_ready), .out_data_o(od1),
    .occ_o(occ1), .stall_cnt_o(sc1), .bubble_cnt_o(bc1)
  );

  y86_elastic_pipe_reg #(.SKID(1'b0), .CNT_W(CW)) u_dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .bubble_i(bubble), .stall_i(stall),
    .in_valid_i(in_valid), .in_ready_o(rdy0), .in_data_i(in_data),
    .out_valid_o(ov0), .out_ready_i(out_ready), .out_data_o(od0),
    .occ_o(occ0), .stall_cnt_o(sc0), .bubble_cnt_o(bc0)
  );

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return DW'(t);
  endfunction

  // One clock cycle: drive inputs, compare at negedge, advance the models at posedge.
  task automatic cycle(input bit r, input bit b, input bit s, input bit v,
                       input logic [DW-1:0] d, input bit o);
    bit e_rdy1, e_v1, e_rdy0, e_v0;
    rst_n = r; bubble = b; stall = s; in_valid = v; in_data = d; out_ready = o;
    @(negedge clk);
    e_v1   = (q1.size() > 0);
    e_v0   = (q0.size() > 0);
    e_rdy1 = (q1.size() < 2) && !s && !b;
    e_rdy0 = (q0.size() == 0 || o) && !s && !b;
    if (known) begin
      check("rdy1", 160'(rdy1), 160'(e_rdy1));
      check("vld1", 160'(ov1), 160'(e_v1));
      check("occ1", 160'(occ1), 160'(q1.size()));
      if (e_v1) check("data1", 160'(od1), 160'(q1[0]));
      check("scnt1", 160'(sc1), 160'(scm));
      check("bcnt1", 160'(bc1), 160'(bcm));
      check("rdy0", 160'(rdy0), 160'(e_rdy0));
      check("vld0", 160'(ov0), 160'(e_v0));
      check("occ0", 160'(occ0), 160'(q0.size()));
      if (e_v0) check("data0", 160'(od0), 160'(q0[0]));
      check("scnt0", 160'(sc0), 160'(scm));
      check("bcnt0", 160'(bc0), 160'(bcm));
    end
    @(posedge clk);
    if (!r) begin
      q1.delete(); q0.delete();
      scm = 0; bcm = 0; known = 1'b1;
    end else begin
      if (s && scm < CMAX) scm++;
      if (b && bcm < CMAX) bcm++;
      if (b) begin
        q1.delete(); q1.push_back(nop);
        q0.delete(); q0.push_back(nop);
      end else begin
        if (e_v1 && o) void'(q1.pop_front());
        if (v && e_rdy1) q1.push_back(d);
        if (e_v0 && o) void'(q0.pop_front());
        if (v && e_rdy0) q0.push_back(d);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b1, rnd(), 1'b0);
  endtask

  initial begin
    logic [DW-1:0] a, b, c;
    nop = DW'(1) << 140;

    // Reset held for three cycles with in_valid asserted
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, rnd(), 1'b1);
    check("rst_occ1", 160'(occ1), 160'(0));
    check("rst_vld1", 160'(ov1), 160'(0));
    check("rst_data1", 160'(od1), 160'(nop));
    check("rst_occ0", 160'(occ0), 160'(0));
    check("rst_data0", 160'(od0), 160'(nop));

    // Back-to-back stream of 1..8, each visible one edge after acceptance
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b1, DW'(i), 1'b1);
      check("strm1", 160'(od1), 160'(i));
      check("strm0", 160'(od0), 160'(i));
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    check("strm_empty1", 160'(occ1), 160'(0));

    // Backpressure: three offers against a blocked consumer
    a = rnd(); b = rnd(); c = rnd();
    cycle(1'b1, 1'b0, 1'b0, 1'b1, a, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, b, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, c, 1'b0);
    check("bp_occ1", 160'(occ1), 160'(2));
    check("bp_rdy1", 160'(rdy1), 160'(0));
    check("bp_occ0", 160'(occ0), 160'(1));
    cycle(1'b1, 1'b0, 1'b0, 1'b1, c, 1'b1);
    check("bp_headB", 160'(od1), 160'(b));
    cycle(1'b1, 1'b0, 1'b0, 1'b1, c, 1'b1);
    check("bp_headC", 160'(od1), 160'(c));
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Bubble and stall together while full
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b1, rnd(), 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, rnd(), 1'b0);
    check("bs_full", 160'(occ1), 160'(2));
    cycle(1'b1, 1'b1, 1'b1, 1'b1, rnd(), 1'b1);
    check("bs_occ", 160'(occ1), 160'(1));
    check("bs_data", 160'(od1), 160'(nop));
    check("bs_bcnt", 160'(bc1), 160'(1));
    check("bs_scnt", 160'(sc1), 160'(1));

    // Stall blocks enqueue while the held entry still drains
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b1, rnd(), 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b1, 1'b1, rnd(), 1'b1);
    check("st_cnt", 160'(sc1), 160'(5));
    check("st_occ1", 160'(occ1), 160'(0));
    check("st_occ0", 160'(occ0), 160'(0));

    // Counter saturation
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b1);
    check("sat_cnt", 160'(sc1), 160'(CMAX));
    cycle(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b1);
    check("sat_hold", 160'(sc0), 160'(CMAX));

    // Randomized traffic against the models
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 63) != 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) != 0),
            rnd(), ($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
